// File: rtl/div_pkg.sv
// Shared types and sizing constants for the iterative restoring divider.
package div_pkg;

  localparam int DIV_LEN   = 32;
  localparam int DIV_CNT_W = $clog2(DIV_LEN);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One radix-2 restoring iteration: shift in the next dividend bit and
// trial-subtract the divisor.
module div_step #(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0] i_rem,
  input  logic           i_msb,
  input  logic [LEN-1:0] i_dvs,
  output logic [LEN-1:0] o_rem,
  output logic           o_qbit
);

  logic [LEN:0] w_shift;
  logic [LEN:0] w_diff;

  // Partial remainder stays below the divisor, so the LEN+1-bit difference
  // lies in (-2^LEN, 2^LEN) and its MSB is a reliable sign bit.
  assign w_shift = {i_rem, i_msb};
  assign w_diff  = w_shift - {1'b0, i_dvs};
  assign o_qbit  = ~w_diff[LEN];
  assign o_rem   = o_qbit ? w_diff[LEN-1:0] : w_shift[LEN-1:0];

endmodule

// File: rtl/divider.sv
// Iterative radix-2 restoring divider for DIV/DIVU/REM/REMU with flush.
// Optional DIV_SPECIAL_FAST_EN: finish divide-by-zero and signed overflow at the load edge.
module divider
  import div_pkg::*;
#(
  parameter int LEN = DIV_LEN
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           is_signed,
  input  logic [LEN-1:0] dividend,
  input  logic [LEN-1:0] divisor,
  input  logic           flush,
  output logic [LEN-1:0] quotient,
  output logic [LEN-1:0] remainder,
  output logic           busy,
  output logic           done
);

  localparam int CNT_W = (LEN == DIV_LEN) ? DIV_CNT_W : $clog2(LEN);

  div_state_e       r_state;
  div_state_e       w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [LEN-1:0]   r_rem;
  logic [LEN-1:0]   r_acc;
  logic [LEN-1:0]   r_dvs;
  logic [LEN-1:0]   r_quotient;
  logic [LEN-1:0]   r_remainder;
  logic             r_q_neg;
  logic             r_r_neg;
  logic             r_dvz;

  logic             w_dvd_neg;
  logic             w_dvs_neg;
  logic [LEN-1:0]   w_dvd_mag;
  logic [LEN-1:0]   w_dvs_mag;
  logic             w_dvs_zero;
  logic             w_fast;
  logic             w_load;
  logic [LEN-1:0]   w_step_rem;
  logic             w_qbit;

  assign w_dvd_neg  = is_signed & dividend[LEN-1];
  assign w_dvs_neg  = is_signed & divisor[LEN-1];
  assign w_dvd_mag  = w_dvd_neg ? (~dividend + 1'b1) : dividend;
  assign w_dvs_mag  = w_dvs_neg ? (~divisor + 1'b1) : divisor;
  assign w_dvs_zero = (divisor == '0);
  assign w_load     = ((r_state == IDLE) || (r_state == DONE)) & start & ~flush;

`ifdef DIV_SPECIAL_FAST_EN
  localparam logic [LEN-1:0] MIN_NEG = {1'b1, {(LEN-1){1'b0}}};
  assign w_fast = w_dvs_zero | (is_signed & (dividend == MIN_NEG) & (divisor == '1));
`else
  assign w_fast = 1'b0;
`endif

  div_step #(.LEN(LEN)) u_step (
    .i_rem  (r_rem),
    .i_msb  (r_acc[LEN-1]),
    .i_dvs  (r_dvs),
    .o_rem  (w_step_rem),
    .o_qbit (w_qbit)
  );

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    w_next = r_state;
    if (flush) begin
      w_next = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: w_next = start ? (w_fast ? DONE : CALC) : IDLE;
        CALC:       if (r_cnt == '0) w_next = FIX;
        FIX:        w_next = DONE;
        default:    w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_acc       <= '0;
      r_dvs       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_q_neg     <= 1'b0;
      r_r_neg     <= 1'b0;
      r_dvz       <= 1'b0;
    end else if (w_load) begin
      r_rem   <= '0;
      r_acc   <= w_dvd_mag;
      r_dvs   <= w_dvs_mag;
      r_q_neg <= w_dvd_neg ^ w_dvs_neg;
      r_r_neg <= w_dvd_neg;
      r_dvz   <= w_dvs_zero;
      r_cnt   <= CNT_W'(LEN - 1);
`ifdef DIV_SPECIAL_FAST_EN
      if (w_fast) begin
        r_quotient  <= w_dvs_zero ? '1 : MIN_NEG;
        r_remainder <= w_dvs_zero ? dividend : '0;
      end
`endif
    end else if (!flush && r_state == CALC) begin
      r_rem <= w_step_rem;
      r_acc <= {r_acc[LEN-2:0], w_qbit};
      r_cnt <= r_cnt - 1'b1;
    end else if (!flush && r_state == FIX) begin
      // Signed overflow needs no override: |MIN|/1 negated twice is MIN, remainder 0.
      r_quotient  <= r_dvz ? '1 : (r_q_neg ? (~r_acc + 1'b1) : r_acc);
      r_remainder <= r_r_neg ? (~r_rem + 1'b1) : r_rem;
    end
  end

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = (r_state == CALC) || (r_state == FIX);
  assign done      = (r_state == DONE);

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider: results, latency, flush, reset.
module tb_divider;

  logic        clock;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        flush;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        busy;
  logic        done;

  int checks   = 0;
  int failures = 0;

`ifdef DIV_SPECIAL_FAST_EN
  localparam int SPECIAL_LAT = 1;
`else
  localparam int SPECIAL_LAT = 34;
`endif

  divider #(.LEN(32)) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .dividend  (dividend),
    .divisor   (divisor),
    .flush     (flush),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic launch(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
  endtask

  // Called in the start cycle (cycle 0); returns in the cycle done is seen.
  task automatic wait_done(input string tag, input int exp_cyc,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input int poke);
    int got_cyc = -1;
    bit busy_ok = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      tick();
      start = (cyc == poke);
      if (cyc == poke) begin
        is_signed = 1'b0;
        dividend  = 32'd9;
        divisor   = 32'd3;
      end
      if (busy !== (cyc < exp_cyc)) busy_ok = 1'b0;
      if (done === 1'b1) begin
        got_cyc = cyc;
        break;
      end
    end
    start = 1'b0;
    check({tag, "_done_cycle"}, 32'(got_cyc), 32'(exp_cyc));
    check({tag, "_busy_window"}, {31'd0, busy_ok}, 32'd1);
    check({tag, "_quotient"}, quotient, exp_q);
    check({tag, "_remainder"}, remainder, exp_r);
  endtask

  initial begin
    bit done_seen;
    reset     = 1'b1;
    start     = 1'b0;
    flush     = 1'b0;
    is_signed = 1'b0;
    dividend  = '0;
    divisor   = '0;

    #3;
    check("rst_quotient", quotient, 32'd0);
    check("rst_remainder", remainder, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    tick();

    launch(1'b0, 32'd100, 32'd7);
    wait_done("udiv_100_7", 34, 32'd14, 32'd2, 0);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("quotient_held", quotient, 32'd14);

    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done("sdiv_m7_2", 34, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 0);
    tick();
    launch(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done("sdiv_7_m2", 34, 32'hFFFF_FFFD, 32'd1, 0);
    tick();
    launch(1'b0, 32'hFFFF_FFFF, 32'h10);
    wait_done("udiv_max_16", 34, 32'h0FFF_FFFF, 32'hF, 0);
    tick();

    launch(1'b0, 32'h1234, 32'd0);
    wait_done("udiv_by_zero", SPECIAL_LAT, 32'hFFFF_FFFF, 32'h1234, 0);
    tick();
    launch(1'b1, 32'h1234, 32'd0);
    wait_done("sdiv_by_zero", SPECIAL_LAT, 32'hFFFF_FFFF, 32'h1234, 0);
    tick();
    launch(1'b1, 32'hFFFF_EDCC, 32'd0);
    wait_done("sdiv_neg_by_zero", SPECIAL_LAT, 32'hFFFF_FFFF, 32'hFFFF_EDCC, 0);
    tick();
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("sdiv_overflow", SPECIAL_LAT, 32'h8000_0000, 32'd0, 0);
    tick();

    launch(1'b0, 32'd200, 32'd7);
    wait_done("start_while_busy", 34, 32'd28, 32'd4, 5);
    tick();

    // Flush in cycle 10, restart in cycle 11, then back-to-back from DONE.
    launch(1'b0, 32'd1000, 32'd3);
    tick();
    start     = 1'b0;
    done_seen = done;
    for (int c = 2; c <= 10; c++) begin
      tick();
      done_seen |= done;
    end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_busy_low", {31'd0, busy}, 32'd0);
    check("flush_no_done", {31'd0, done_seen | done}, 32'd0);
    launch(1'b0, 32'd50, 32'd5);
    wait_done("post_flush_50_5", 34, 32'd10, 32'd0, 0);
    launch(1'b0, 32'd83, 32'd9);
    wait_done("b2b_83_9", 34, 32'd9, 32'd2, 0);

    tick();
    flush = 1'b1;
    launch(1'b0, 32'd40, 32'd4);
    tick();
    flush = 1'b0;
    start = 1'b0;
    check("flush_beats_start", {31'd0, busy}, 32'd0);
    tick();
    check("flush_beats_start_q", quotient, 32'd9);

    launch(1'b0, 32'd1000, 32'd3);
    tick();
    start = 1'b0;
    repeat (19) tick();
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_quotient", quotient, 32'd0);
    check("async_rst_remainder", remainder, 32'd0);
    check("async_rst_busy", {31'd0, busy}, 32'd0);
    check("async_rst_done", {31'd0, done}, 32'd0);
    #1;
    reset = 1'b0;
    tick();
    launch(1'b1, 32'hFFFF_FF9C, 32'd7);
    wait_done("after_reset_m100_7", 34, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
